// File: rtl/pipe_ripple_adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder.
// A stage record holds the sum bits resolved so far (low part) and the operand
// bits not yet consumed (high part); the helpers below give those field widths.
package pipe_ripple_adder_pkg;

    // Bits resolved per pipeline stage.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal configurations: 1..width stages, width an exact multiple of stages.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Width of the resolved-sum field held by stage k.
    function automatic int sum_w(input int width, input int stages, input int k);
        return (k + 1) * chunk_w(width, stages);
    endfunction

    // Width of the not-yet-added operand field held by stage k.
    function automatic int upper_w(input int width, input int stages, input int k);
        return width - sum_w(width, stages, k);
    endfunction

endpackage

// File: rtl/pipe_ripple_adder_if.sv
// Operand/result handshake bundle for pipe_ripple_adder.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_ripple_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;
`endif

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout
`ifdef PIPE_ADDER_OVF_EN
        , output ovf
`endif
    );

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout
`ifdef PIPE_ADDER_OVF_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/pipe_ripple_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry full-adder chain.
module pipe_ripple_adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    // Bit-serial carry chain from bit 0 upward.
    always_comb begin
        logic [CHUNK:0] c;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[CHUNK];
    end

endmodule

// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder, STAGES chunks of WIDTH/STAGES bits, one add per cycle.
// The whole pipe advances together (en); bubbles are not collapsed.
// Optional feature macro: PIPE_ADDER_OVF_EN adds the signed-overflow output.
module pipe_ripple_adder
    import pipe_ripple_adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_ripple_adder_if.slave   bus
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_ripple_adder: STAGES must be 1..WIDTH and divide WIDTH");
    end

    logic en;

    assign en           = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = sum_w(WIDTH, STAGES, k);
        localparam int UW = upper_w(WIDTH, STAGES, k);

        logic [CHUNK-1:0] a_ch;
        logic [CHUNK-1:0] b_ch;
        logic [CHUNK-1:0] sum_ch;
        logic             ci;
        logic             co;
        logic             v_src;
        logic [SW-1:0]    s_next;
        logic             v_q;
        logic             c_q;
        logic [SW-1:0]    s_q;

        if (k == 0) begin : g_head
            assign a_ch   = bus.a[CHUNK-1:0];
            assign b_ch   = bus.b[CHUNK-1:0];
            assign ci     = bus.cin;
            assign v_src  = bus.in_valid;
            assign s_next = sum_ch;
        end else begin : g_body
            assign a_ch   = g_stage[k-1].g_up.a_q[CHUNK-1:0];
            assign b_ch   = g_stage[k-1].g_up.b_q[CHUNK-1:0];
            assign ci     = g_stage[k-1].c_q;
            assign v_src  = g_stage[k-1].v_q;
            assign s_next = {sum_ch, g_stage[k-1].s_q};
        end

        pipe_ripple_adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a  (a_ch),
            .b  (b_ch),
            .ci (ci),
            .s  (sum_ch),
            .co (co)
        );

        // Valid bit, carry and resolved sum bits of this stage.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_src;
                c_q <= co;
                s_q <= s_next;
            end
        end

        // Operand bits still waiting for a later stage; absent in the last stage.
        if (UW > 0) begin : g_up
            logic [UW-1:0] a_q;
            logic [UW-1:0] b_q;

            if (k == 0) begin : g_src_in
                // Capture the upper operand bits straight from the inputs.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (en) begin
                        a_q <= bus.a[WIDTH-1:CHUNK];
                        b_q <= bus.b[WIDTH-1:CHUNK];
                    end
                end
            end else begin : g_src_prev
                // Pass along everything above the chunk this stage just consumed.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (en) begin
                        a_q <= g_stage[k-1].g_up.a_q[UW+CHUNK-1:CHUNK];
                        b_q <= g_stage[k-1].g_up.b_q[UW+CHUNK-1:CHUNK];
                    end
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.s         = g_stage[STAGES-1].s_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;

    // Operand MSBs arrive with the top chunk, so overflow resolves in the last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= (g_stage[STAGES-1].a_ch[CHUNK-1] == g_stage[STAGES-1].b_ch[CHUNK-1]) &&
                     (g_stage[STAGES-1].sum_ch[CHUNK-1] != g_stage[STAGES-1].a_ch[CHUNK-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Self-checking bench: four adders (STAGES 2, 1, 4, 8; WIDTH 8) share one stimulus.
// Each keeps its own expected-result queue fed on input transfers and drained on
// output transfers; values come from plain integer arithmetic.
module tb_pipe_ripple_adder;

    localparam int W  = 8;
    localparam int ND = 4;

    function automatic int st_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           n;
        bit           lit;
        logic [W-1:0] ls;
        logic         lc;
    } item_t;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         cin       = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;

    logic         ov [ND];
    logic         ir [ND];
    logic         co [ND];
    logic [W-1:0] sv [ND];
`ifdef PIPE_ADDER_OVF_EN
    logic         of [ND];
`endif

    int           checks   = 0;
    int           failures = 0;
    int           edge_cnt = 0;
    int           last_stall [ND];
    bit           held [ND];
    logic [W-1:0] hs [ND];
    logic         hc [ND];
    item_t        sb [ND][$];

    bit           lit   = 1'b0;
    logic [W-1:0] lit_s = '0;
    logic         lit_c = 1'b0;
    bit           end_req = 1'b0;
    bit           end_ack = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        pipe_ripple_adder_if #(.WIDTH(W)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.a         = a;
        assign bus.b         = b;
        assign bus.cin       = cin;
        assign bus.out_ready = out_ready;
        assign ov[g] = bus.out_valid;
        assign ir[g] = bus.in_ready;
        assign co[g] = bus.cout;
        assign sv[g] = bus.s;
`ifdef PIPE_ADDER_OVF_EN
        assign of[g] = bus.ovf;
`endif

        pipe_ripple_adder #(
            .WIDTH  (W),
            .STAGES (st_of(g))
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    // Reference: exact integer sum, and signed overflow as an out-of-range signed result.
    function automatic item_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic ci, input int n);
        item_t m;
        int    u;
        int    sg;
        u    = int'(x) + int'(y) + int'(ci);
        sg   = int'($signed(x)) + int'($signed(y)) + int'(ci);
        m.s  = u[W-1:0];
        m.c  = (u >= (1 << W));
        m.o  = (sg > 127) || (sg < -128);
        m.n  = n;
        m.lit = 1'b0;
        m.ls = '0;
        m.lc = 1'b0;
        return m;
    endfunction

    initial begin
        for (int d = 0; d < ND; d++) begin
            last_stall[d] = 0;
            held[d]       = 1'b0;
            hs[d]         = '0;
            hc[d]         = 1'b0;
        end
    end

    always @(posedge clk) edge_cnt++;

    // Single compare process: every negedge, for every adder.
    always @(negedge clk) begin
        item_t it;
        int    lat;
        bit    bad;
        for (int d = 0; d < ND; d++) begin
            if (reset) begin
                checks++;
                bad = (ov[d] !== 1'b0) || (sv[d] !== '0) || (co[d] !== 1'b0) || (ir[d] !== 1'b1);
`ifdef PIPE_ADDER_OVF_EN
                bad = bad || (of[d] !== 1'b0);
`endif
                if (bad) begin
                    failures++;
                    $display("FAIL reset_state st=%0d: out_valid=%b s=%h cout=%b in_ready=%b, need 0 00 0 1",
                             st_of(d), ov[d], sv[d], co[d], ir[d]);
                end
                sb[d].delete();
                held[d] = 1'b0;
            end else begin
                if (held[d]) begin
                    checks++;
                    if (ov[d] !== 1'b1 || sv[d] !== hs[d] || co[d] !== hc[d]) begin
                        failures++;
                        $display("FAIL hold st=%0d: out_valid=%b s=%h cout=%b, need 1 %h %b",
                                 st_of(d), ov[d], sv[d], co[d], hs[d], hc[d]);
                    end
                end
                checks++;
                if (ir[d] !== (!ov[d] || out_ready)) begin
                    failures++;
                    $display("FAIL in_ready st=%0d: got %b with out_valid=%b out_ready=%b",
                             st_of(d), ir[d], ov[d], out_ready);
                end
                if (ov[d] === 1'b1 && out_ready) begin
                    checks++;
                    if (sb[d].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_result st=%0d: s=%h cout=%b with nothing outstanding",
                                 st_of(d), sv[d], co[d]);
                    end else begin
                        it  = sb[d].pop_front();
                        bad = (sv[d] !== it.s) || (co[d] !== it.c);
`ifdef PIPE_ADDER_OVF_EN
                        bad = bad || (of[d] !== it.o);
`endif
                        if (bad) begin
                            failures++;
                            $display("FAIL sum st=%0d: s=%h cout=%b, need s=%h cout=%b (ovf need %b)",
                                     st_of(d), sv[d], co[d], it.s, it.c, it.o);
                        end
                        if (it.n > last_stall[d]) begin
                            checks++;
                            lat = edge_cnt + 1 - it.n;
                            if (lat != st_of(d)) begin
                                failures++;
                                $display("FAIL latency st=%0d: got %0d cycles, need %0d",
                                         st_of(d), lat, st_of(d));
                            end
                        end
                        if (it.lit) begin
                            checks++;
                            if (sv[d] !== it.ls || co[d] !== it.lc) begin
                                failures++;
                                $display("FAIL literal st=%0d: s=%h cout=%b, need s=%h cout=%b",
                                         st_of(d), sv[d], co[d], it.ls, it.lc);
                            end
                        end
                    end
                end
                held[d] = (ov[d] === 1'b1) && !out_ready;
                hs[d]   = sv[d];
                hc[d]   = co[d];
                if (held[d]) last_stall[d] = edge_cnt + 1;
                if (in_valid && ir[d] === 1'b1) begin
                    it     = model(a, b, cin, edge_cnt + 1);
                    it.lit = lit;
                    it.ls  = lit_s;
                    it.lc  = lit_c;
                    sb[d].push_back(it);
                end
            end
        end
        if (end_req && !end_ack) begin
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (sb[d].size() != 0) begin
                    failures++;
                    $display("FAIL drain st=%0d: %0d results outstanding, need 0",
                             st_of(d), sb[d].size());
                end
            end
            end_ack = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic [W-1:0] es, input logic ec);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        lit      = 1'b1;
        lit_s    = es;
        lit_c    = ec;
        step();
        in_valid = 1'b0;
        lit      = 1'b0;
    endtask

    task automatic put_rand();
        in_valid = 1'b1;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        lit      = 1'b0;
        step();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        put(8'd3, 8'd4, 1'b0, 8'd7, 1'b0);
        repeat (3) step();
        put(8'd3, 8'd4, 1'b1, 8'd8, 1'b0);
        repeat (3) step();

        put(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        put(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        put(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        repeat (10) step();

        put(8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        put(8'd1, 8'd0, 1'b0, 8'd1, 1'b0);
        put(8'd1, 8'd1, 1'b0, 8'd2, 1'b0);
        put(8'd3, 8'd4, 1'b0, 8'd7, 1'b0);
        put(8'd4, 8'd5, 1'b0, 8'd9, 1'b0);
        repeat (10) step();

        for (int i = 0; i < 8; i++) put_rand();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) put_rand();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) put_rand();
        in_valid = 1'b0;
        repeat (12) step();

        put(8'h11, 8'h22, 1'b0, 8'h33, 1'b0);
        put(8'h40, 8'h40, 1'b1, 8'h81, 1'b0);
        #1 reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (12) step();

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            if ((i % 700) == 350) reset = 1'b1;
            step();
            reset = 1'b0;
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();

        end_req = 1'b1;
        for (int k = 0; k < 10 && !end_ack; k++) step();
        if (!end_ack) begin
            $display("FAIL end_handshake: no final check within 10 cycles");
            $fatal(1, "end handshake timeout");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
